// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS32 core: reset/NOP constants,
// fetch FSM states and the IF/ID pipeline bundle.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
// A bubble replaces instr/valid only; pc and pc4 keep their last values.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t data_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d.instr = NOP_INSTR;
            q_d.valid = 1'b0;
        end else if (load_i) begin
            q_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q.instr <= NOP_INSTR;
            q_q.pc    <= '0;
            q_q.pc4   <= '0;
            q_q.valid <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem handshake with one-entry skid buffer,
// redirect kill of in-flight requests, and the IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EnableF,
    input  logic            EnableD,
    input  logic            RstD,
    input  logic            BranchTakenD,
    input  logic [XLEN-1:0] BranchTargetD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;

    logic            redir;
    logic [XLEN-1:0] target;
    logic            idl_load;
    logic            idl_bubble;
    if_id_t          idl_data;
    if_id_t          idl_q;

    assign redir  = BranchTakenD & EnableD;
    assign target = word_align(BranchTargetD);

    always_comb begin
        state_d        = state_q;
        pcf_d          = pcf_q;
        req_addr_d     = req_addr_q;
        buf_instr_d    = buf_instr_q;
        buf_pc_d       = buf_pc_q;
        idl_load       = 1'b0;
        idl_bubble     = 1'b0;
        idl_data.instr = imem_rdata;
        idl_data.pc    = req_addr_q;
        idl_data.pc4   = req_addr_q + 32'd4;
        idl_data.valid = 1'b1;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (redir) begin
                        pcf_d      = target;
                        req_addr_d = target;
                        idl_bubble = 1'b1;
                    end else if (EnableD && EnableF) begin
                        idl_load   = 1'b1;
                        pcf_d      = req_addr_q + 32'd4;
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
                        // Stalled with data in hand: park it rather than re-fetch
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_addr_q;
                        state_d     = HOLD;
                        idl_bubble  = EnableD;
                    end
                end else begin
                    if (redir) begin
                        pcf_d   = target;
                        state_d = KILL;
                    end
                    idl_bubble = EnableD;
                end
            end
            HOLD: begin
                if (redir) begin
                    pcf_d      = target;
                    req_addr_d = target;
                    state_d    = FETCH;
                    idl_bubble = 1'b1;
                end else if (EnableD && EnableF) begin
                    idl_data.instr = buf_instr_q;
                    idl_data.pc    = buf_pc_q;
                    idl_data.pc4   = buf_pc_q + 32'd4;
                    idl_load       = 1'b1;
                    pcf_d          = buf_pc_q + 32'd4;
                    req_addr_d     = buf_pc_q + 32'd4;
                    state_d        = FETCH;
                end else begin
                    idl_bubble = EnableD;
                end
            end
            KILL: begin
                // Stale request must complete; the latest redirect target wins
                if (redir) begin
                    pcf_d = target;
                end
                if (imem_ack) begin
                    req_addr_d = redir ? target : pcf_q;
                    state_d    = FETCH;
                end
                idl_bubble = EnableD;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (RstD) begin
            idl_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pcf_q       <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (idl_load),
        .bubble_i(idl_bubble),
        .data_i  (idl_data),
        .q_o     (idl_q)
    );

    assign imem_req  = (state_q != HOLD);
    assign imem_addr = req_addr_q;
    assign InstrD    = idl_q.instr;
    assign PCD       = idl_q.pc;
    assign PCPlus4D  = idl_q.pc4;
    assign ValidD    = idl_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table on zero-wait memory plus
// hand sequences for wait states, killed requests and mid-wait reset.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        EnableF;
    logic        EnableD;
    logic        RstD;
    logic        BranchTakenD;
    logic [31:0] BranchTargetD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_vec = 0;
    int n_err = 0;

    if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EnableF      (EnableF),
        .EnableD      (EnableD),
        .RstD         (RstD),
        .BranchTakenD (BranchTakenD),
        .BranchTargetD(BranchTargetD),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: returns the address as data after n_wait unacked cycles
    int unsigned n_wait = 0;
    int unsigned wcnt;
    int          acks8 = 0;

    assign imem_ack   = imem_req && (wcnt == n_wait);
    assign imem_rdata = imem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (rst_n && imem_req && imem_ack && imem_addr == 32'h8) acks8 <= acks8 + 1;
    end

    typedef struct {
        logic        ef;
        logic        ed;
        logic        rd;
        logic        br;
        logic [31:0] tgt;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic ef, input logic ed, input logic rd, input logic br,
                                input logic [31:0] tgt, input logic v, input logic [31:0] pc);
        vec_t r;
        r.ef = ef; r.ed = ed; r.rd = rd; r.br = br; r.tgt = tgt;
        r.exp_valid = v; r.exp_pc = pc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ef, input logic ed, input logic rd, input logic br,
                         input logic [31:0] tgt);
        EnableF = ef; EnableD = ed; RstD = rd; BranchTakenD = br; BranchTargetD = tgt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_valid(input string name, input logic [31:0] pc);
        check({name, ".ValidD"},   32'(ValidD), 32'd1);
        check({name, ".PCD"},      PCD,         pc);
        check({name, ".PCPlus4D"}, PCPlus4D,    pc + 32'd4);
        check({name, ".InstrD"},   InstrD,      pc);
    endtask

    task automatic check_bubble(input string name);
        check({name, ".ValidD"}, 32'(ValidD), 32'd0);
        check({name, ".InstrD"}, InstrD,      32'h0);
    endtask

    task automatic do_reset(input int unsigned waits);
        @(negedge clk);
        rst_n = 1'b0;
        n_wait = waits;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #12;
        check("rst.InstrD",   InstrD,            32'h0);
        check("rst.ValidD",   32'(ValidD),       32'd0);
        check("rst.PCD",      PCD,               32'h0);
        check("rst.PCPlus4D", PCPlus4D,          32'h0);
        check("rst.addr",     imem_addr,         32'h0);
        rst_n = 1'b1;
        #1;
        check("rst.req",      32'(imem_req),     32'd1);

        // Zero-wait table: stalls, decode-only stall, flush, redirects, wrap
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h500,       1'b1, 32'h4);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4);
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'hC);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h10);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h18);
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h103,       1'b0, 32'h18);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 32'h100);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].ef, tbl[i].ed, tbl[i].rd, tbl[i].br, tbl[i].tgt);
            tick();
            check($sformatf("vec%0d.ValidD", i),   32'(ValidD), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d.PCD", i),      PCD,         tbl[i].exp_pc);
            check($sformatf("vec%0d.PCPlus4D", i), PCPlus4D,    tbl[i].exp_pc + 32'd4);
            check($sformatf("vec%0d.InstrD", i),   InstrD,
                  tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
        end
        check("stall.acks_to_8", 32'(acks8), 32'd1);

        // Two wait states: two bubbles then one instruction, address stable
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                tick();
                check_bubble($sformatf("w2.k%0d.j%0d", k, j));
                check($sformatf("w2.k%0d.j%0d.addr", k, j), imem_addr, 32'(4 * k));
            end
            tick();
            check_valid($sformatf("w2.k%0d", k), 32'(4 * k));
        end

        // Redirect while a 3-wait request to 0x20 is outstanding
        do_reset(0);
        for (int k = 0; k < 8; k++) tick();
        check_valid("pre_kill", 32'h1C);
        n_wait = 3;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_bubble("kill.a");
        check("kill.a.addr", imem_addr, 32'h20);
        check("kill.a.req",  32'(imem_req), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_bubble($sformatf("kill.w%0d", k));
            check($sformatf("kill.w%0d.addr", k), imem_addr, 32'h20);
        end
        tick();
        check_bubble("kill.ack");
        check("kill.ack.addr", imem_addr, 32'h200);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bubble($sformatf("tgt.w%0d", k));
            check($sformatf("tgt.w%0d.addr", k), imem_addr, 32'h200);
        end
        tick();
        check_valid("tgt", 32'h200);

        // Reset asserted in the middle of a wait
        tick();
        check("midrst.pre.PCD", PCD, 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.InstrD",   InstrD,      32'h0);
        check("midrst.ValidD",   32'(ValidD), 32'd0);
        check("midrst.PCD",      PCD,         32'h0);
        check("midrst.PCPlus4D", PCPlus4D,    32'h0);
        check("midrst.addr",     imem_addr,   32'h0);
        n_wait = 0;
        rst_n = 1'b1;
        tick();
        check_valid("post_rst", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core. Owns the program counter, the request/acknowledge handshake to instruction memory, and the registered decode-stage outputs. Sits directly upstream of decode and consumes the stall and flush controls produced by the hazard unit: EnableF, EnableD and RstD. Variable-latency memory is absorbed by inserting bubbles into decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000 (sll $0,$0,0), instruction word driven during bubbles.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EnableF  in  1  hazard unit; 0 freezes PC.
- EnableD  in  1  hazard unit; 0 freezes the IF/ID register.
- RstD  in  1  hazard unit; 1 loads a bubble into IF/ID.
- BranchTakenD  in  1  redirect request from decode; qualified by EnableD.
- BranchTargetD  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address; held stable while imem_req=1 and no ack.
- imem_ack  in  1  rdata valid; may be asserted in the same cycle as the request (zero wait).
- imem_rdata  in  32  instruction word.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  1 = real instruction, 0 = bubble.

## Operation
- Registers:
  - PCF: next PC to fetch.
  - ReqAddr: the outstanding address, which drives imem_addr.
  - Buf: one-entry skid buffer (instruction plus PC).
  - FSM state.
  - IF/ID output register.
- FSM states:
  - FETCH: imem_req=1.
  - HOLD: imem_req=0; Buf is full.
  - KILL: imem_req=1 on the stale address; the response will be dropped.
- Redirect condition: redir = BranchTakenD & EnableD.
- Priority, per edge: reset > redir or RstD > stall > normal.
- FETCH, ack=1:
  - redir=1: drop rdata. PCF, ReqAddr <= BranchTargetD. Stay in FETCH.
  - EnableD=1, EnableF=1: IF/ID <= {rdata, ReqAddr, ReqAddr+4, valid=1}. PCF, ReqAddr <= ReqAddr+4.
  - EnableD=0 or EnableF=0: Buf <= {rdata, ReqAddr}. Go to HOLD. PCF holds.
- FETCH, ack=0:
  - redir=1: PCF <= target. Go to KILL; ReqAddr is unchanged.
  - Otherwise, if EnableD=1, IF/ID <= bubble.
- HOLD:
  - EnableD=1, EnableF=1, no redir: IF/ID <= Buf with valid=1. PCF, ReqAddr <= Buf.pc+4. Go to FETCH.
  - redir=1: discard Buf. PCF, ReqAddr <= target. Go to FETCH.
- KILL:
  - ack=1: drop rdata. ReqAddr <= PCF. Go to FETCH.
  - redir=1 in KILL: PCF <= target (last redirect wins).
- RstD=1: at the next edge, IF/ID <= bubble, regardless of EnableD or ack. This has priority over every IF/ID load above.
- Bubble contents: InstrD=NOP_INSTR, ValidD=0. PCD and PCPlus4D hold their previous values.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment exceptions are generated.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - PCF = ReqAddr = RESET_PC; state = FETCH; imem_req = 1 after release.
  - InstrD = NOP_INSTR, ValidD = 0, PCD = 0, PCPlus4D = 0; Buf empty.
- Reset mid-request abandons the outstanding access. Memory must tolerate a dropped request.
- Zero-wait memory: one instruction per cycle; fetch-to-ValidD latency is 1 cycle.
- N-wait memory: N bubbles precede each instruction.
- Redirect penalty:
  - 1 cycle when the outstanding request acks in the redirect cycle.
  - Otherwise, the remaining latency of the killed request plus 1.
- Simultaneous ack with a stall: the instruction is preserved in Buf; there is no re-fetch.

## Structure
- Shared package `cpu_pkg`: NOP_INSTR, RESET_PC default, the fetch FSM state enum (FETCH, HOLD, KILL), and the IF/ID bundle struct {instr, pc, pc4, valid}.
- Sub-module `if_id_reg`: the IF/ID register with load, bubble and hold controls. The FSM and PC logic stay in `if_stage`.

## Test plan
- Reset, zero-wait memory returning addr as data: ValidD=1 from cycle 1; PCD sequence 0, 4, 8, 12; InstrD equals PCD.
- Memory with 2 wait states: pattern of two bubbles (ValidD=0, InstrD=0) then one instruction, repeating. imem_addr is stable across each wait.
- EnableF=EnableD=0 for 3 cycles while ack=1 at PC=8: PCD holds; after release PCD=8, then 12. Exactly one request to address 8.
- BranchTakenD=1 with target 0x100 and RstD=1, with ack the same cycle: next ValidD=0, then PCD=0x100. The wrong-path word never reaches ValidD=1.
- Redirect while a 3-wait request to 0x20 is pending: imem_addr stays 0x20 until ack, then 0x200 (target). No ValidD=1 for 0x20.
- Start at PC=32'hFFFF_FFF8: PCD wraps FFFF_FFF8, FFFF_FFFC, 0000_0000. rst_n pulsed low mid-wait returns all outputs to reset values within the same cycle.
